// File: rtl/ddin.sv
// MII receive nibble-to-byte assembler: strips preamble/SFD, pairs nibbles
// low-first into bytes and marks frame start, end, length and error.
module ddin #(
    parameter int MAXLEN  = 1518,
    parameter int PRE_MIN = 2
) (
    input  logic        rxclk_i,
    input  logic        rst_n,
    input  logic        rxdv_i,
    input  logic        rxer_i,
    input  logic [3:0]  dat_i,
    output logic [7:0]  dat_o,
    output logic        rxen_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        rxerr_o,
    output logic [10:0] len_o
);

    // state  | meaning
    // S_IDLE | waiting for carrier
    // S_PRE  | counting 0x5 preamble nibbles, looking for SFD 0xD
    // S_DATA | assembling bytes until rxdv_i falls
    // S_DROP | bad preamble or aborted frame, ignored until rxdv_i falls
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    localparam logic [10:0] MAXLEN_C  = 11'(MAXLEN);
    localparam logic [4:0]  PRE_MIN_C = 5'(PRE_MIN);

    state_t      r_state,    w_state_nxt;
    logic [3:0]  r_pre_cnt,  w_pre_cnt_nxt;
    logic [10:0] r_byte_cnt, w_byte_cnt_nxt;
    logic        r_phase,    w_phase_nxt;
    logic        r_err,      w_err_nxt;
    logic [3:0]  r_lo,       w_lo_nxt;
    logic [7:0]  r_dat,      w_dat_nxt;
    logic        r_rxen,     w_rxen_nxt;
    logic        r_sof,      w_sof_nxt;
    logic        r_eof,      w_eof_nxt;
    logic        r_rxerr,    w_rxerr_nxt;
    logic [10:0] r_len,      w_len_nxt;

    always_ff @(posedge rxclk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pre_cnt  <= '0;
            r_byte_cnt <= '0;
            r_phase    <= 1'b0;
            r_err      <= 1'b0;
            r_lo       <= '0;
            r_dat      <= '0;
            r_rxen     <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_rxerr    <= 1'b0;
            r_len      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pre_cnt  <= w_pre_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_err      <= w_err_nxt;
            r_lo       <= w_lo_nxt;
            r_dat      <= w_dat_nxt;
            r_rxen     <= w_rxen_nxt;
            r_sof      <= w_sof_nxt;
            r_eof      <= w_eof_nxt;
            r_rxerr    <= w_rxerr_nxt;
            r_len      <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pre_cnt_nxt  = r_pre_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_phase_nxt    = r_phase;
        w_err_nxt      = r_err;
        w_lo_nxt       = r_lo;
        w_dat_nxt      = r_dat;
        w_rxen_nxt     = 1'b0;
        w_sof_nxt      = 1'b0;
        w_eof_nxt      = 1'b0;
        w_rxerr_nxt    = 1'b0;
        w_len_nxt      = r_len;

        case (r_state)
            S_IDLE: begin
                if (rxdv_i) begin
                    if (dat_i == 4'h5) begin
                        w_state_nxt   = S_PRE;
                        w_pre_cnt_nxt = 4'd1;
                    end else begin
                        w_state_nxt = S_DROP;
                    end
                end
            end
            S_PRE: begin
                if (!rxdv_i) begin
                    w_state_nxt = S_IDLE;
                end else if (dat_i == 4'h5) begin
                    if (r_pre_cnt != 4'hF)
                        w_pre_cnt_nxt = r_pre_cnt + 4'd1;
                end else if (dat_i == 4'hD && {1'b0, r_pre_cnt} >= PRE_MIN_C) begin
                    w_state_nxt    = S_DATA;
                    w_phase_nxt    = 1'b0;
                    w_byte_cnt_nxt = '0;
                    w_err_nxt      = 1'b0;
                end else begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (rxdv_i) begin
                    if (rxer_i)
                        w_err_nxt = 1'b1;
                    if (!r_phase) begin
                        w_lo_nxt    = dat_i;
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = 1'b0;
                        if (r_byte_cnt < MAXLEN_C) begin
                            w_dat_nxt      = {dat_i, r_lo};
                            w_rxen_nxt     = 1'b1;
                            w_sof_nxt      = (r_byte_cnt == '0);
                            w_byte_cnt_nxt = r_byte_cnt + 11'd1;
                        end else begin
                            // oversize: keep the count pinned and flag the frame
                            w_err_nxt = 1'b1;
                        end
                    end
                end else begin
                    w_eof_nxt   = 1'b1;
                    w_len_nxt   = r_byte_cnt;
                    w_rxerr_nxt = r_err | r_phase | (r_byte_cnt == '0);
                    w_phase_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (!rxdv_i)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign dat_o   = r_dat;
    assign rxen_o  = r_rxen;
    assign sof_o   = r_sof;
    assign eof_o   = r_eof;
    assign rxerr_o = r_rxerr;
    assign len_o   = r_len;

endmodule

// File: tb/tb_ddin.sv
// Directed bench for ddin: a default instance plus a MAXLEN=4 instance
// sharing the same MII receive stimulus.
module tb_ddin;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxdv = 1'b0;
    logic        rxer = 1'b0;
    logic [3:0]  dat = '0;

    logic [7:0]  dat_a, dat_b;
    logic        rxen_a, sof_a, eof_a, rxerr_a;
    logic        rxen_b, sof_b, eof_b, rxerr_b;
    logic [10:0] len_a, len_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddin u_dut_a (
        .rxclk_i(clk), .rst_n(rst_n), .rxdv_i(rxdv), .rxer_i(rxer), .dat_i(dat),
        .dat_o(dat_a), .rxen_o(rxen_a), .sof_o(sof_a), .eof_o(eof_a),
        .rxerr_o(rxerr_a), .len_o(len_a)
    );

    ddin #(.MAXLEN(4)) u_dut_b (
        .rxclk_i(clk), .rst_n(rst_n), .rxdv_i(rxdv), .rxer_i(rxer), .dat_i(dat),
        .dat_o(dat_b), .rxen_o(rxen_b), .sof_o(sof_b), .eof_o(eof_b),
        .rxerr_o(rxerr_b), .len_o(len_b)
    );

    logic [7:0] tx_q[$];
    logic [7:0] byte_q[$];
    logic       sof_q[$];
    int         strb_cyc_q[$];
    int         cyc = 0;
    int         n_eof_a, n_eof_b, n_strb_b;
    logic [10:0] last_len_a, last_len_b;
    logic        last_err_a, last_err_b;
    logic        prev_rxen_a = 1'b0;
    int          n_b2b = 0;
    int          n_stray_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int idx);
        return (idx < byte_q.size()) ? byte_q[idx] : 8'hxx;
    endfunction

    function automatic logic sof_at(input int idx);
        return (idx < sof_q.size()) ? sof_q[idx] : 1'bx;
    endfunction

    task automatic clear_mon();
        byte_q.delete();
        sof_q.delete();
        strb_cyc_q.delete();
        n_eof_a = 0;
        n_eof_b = 0;
        n_strb_b = 0;
        last_len_a = 'x;
        last_len_b = 'x;
        last_err_a = 1'bx;
        last_err_b = 1'bx;
    endtask

    // one MII cycle: drive on the falling edge, observe just after the rising edge
    task automatic clk_nib(input logic dv, input logic er, input logic [3:0] d);
        @(negedge clk);
        rxdv = dv;
        rxer = er;
        dat  = d;
        @(posedge clk);
        #1;
        cyc++;
        if (rxen_a) begin
            byte_q.push_back(dat_a);
            sof_q.push_back(sof_a);
            strb_cyc_q.push_back(cyc);
        end
        if (rxen_a && prev_rxen_a)
            n_b2b++;
        prev_rxen_a = rxen_a;
        if (rxerr_a && !eof_a)
            n_stray_err++;
        if (eof_a) begin
            n_eof_a++;
            last_len_a = len_a;
            last_err_a = rxerr_a;
        end
        if (rxen_b)
            n_strb_b++;
        if (eof_b) begin
            n_eof_b++;
            last_len_b = len_b;
            last_err_b = rxerr_b;
        end
    endtask

    task automatic send_frame(input int npre, input bit odd, input int er_nib);
        for (int i = 0; i < npre; i++)
            clk_nib(1'b1, 1'b0, 4'h5);
        clk_nib(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < tx_q.size(); i++) begin
            clk_nib(1'b1, (2*i) == er_nib, tx_q[i][3:0]);
            clk_nib(1'b1, (2*i+1) == er_nib, tx_q[i][7:4]);
        end
        if (odd)
            clk_nib(1'b1, 1'b0, 4'h7);
        clk_nib(1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", {dat_a, len_a, rxen_a, sof_a, eof_a, rxerr_a}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        clk_nib(1'b0, 1'b0, 4'h0);

        // normal frame
        clear_mon();
        tx_q = '{8'h12, 8'hAB};
        send_frame(15, 1'b0, -1);
        check_val("t1_nbytes", byte_q.size(), 2);
        check_val("t1_byte0", byte_at(0), 8'h12);
        check_val("t1_sof0", sof_at(0), 1'b1);
        check_val("t1_byte1", byte_at(1), 8'hAB);
        check_val("t1_sof1", sof_at(1), 1'b0);
        check_val("t1_spacing", (strb_cyc_q.size() == 2) ? strb_cyc_q[1] - strb_cyc_q[0] : -1, 2);
        check_val("t1_eof", n_eof_a, 1);
        check_val("t1_len", last_len_a, 2);
        check_val("t1_err", last_err_a, 1'b0);
        check_val("t1_eof_gap", cyc - ((strb_cyc_q.size() == 2) ? strb_cyc_q[1] : 0), 1);

        // odd trailing nibble
        clear_mon();
        send_frame(15, 1'b1, -1);
        check_val("t2_nbytes", byte_q.size(), 2);
        check_val("t2_len", last_len_a, 2);
        check_val("t2_err", last_err_a, 1'b1);

        // rxer during second byte
        clear_mon();
        send_frame(15, 1'b0, 2);
        check_val("t3_nbytes", byte_q.size(), 2);
        check_val("t3_byte1", byte_at(1), 8'hAB);
        check_val("t3_len", last_len_a, 2);
        check_val("t3_err", last_err_a, 1'b1);

        // bad preamble then a good frame straight after
        clear_mon();
        clk_nib(1'b1, 1'b0, 4'h5);
        clk_nib(1'b1, 1'b0, 4'h5);
        clk_nib(1'b1, 1'b0, 4'h3);
        clk_nib(1'b1, 1'b0, 4'hD);
        clk_nib(1'b1, 1'b0, 4'h1);
        clk_nib(1'b1, 1'b0, 4'h2);
        clk_nib(1'b0, 1'b0, 4'h0);
        check_val("t4_bad_nbytes", byte_q.size(), 0);
        check_val("t4_bad_eof", n_eof_a, 0);
        send_frame(15, 1'b0, -1);
        check_val("t4_good_nbytes", byte_q.size(), 2);
        check_val("t4_good_byte0", byte_at(0), 8'h12);
        check_val("t4_good_byte1", byte_at(1), 8'hAB);
        check_val("t4_good_len", last_len_a, 2);
        check_val("t4_good_err", last_err_a, 1'b0);

        // length limit on the MAXLEN=4 instance
        clear_mon();
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(7, 1'b0, -1);
        check_val("t5_b_strobes", n_strb_b, 4);
        check_val("t5_b_eof", n_eof_b, 1);
        check_val("t5_b_len", last_len_b, 4);
        check_val("t5_b_err", last_err_b, 1'b1);
        check_val("t5_a_len", last_len_a, 6);
        check_val("t5_a_err", last_err_a, 1'b0);
        check_val("t5_a_byte5", byte_at(5), 8'h06);

        // SFD after a single preamble nibble is below PRE_MIN
        clear_mon();
        tx_q = '{8'h77, 8'h88};
        send_frame(1, 1'b0, -1);
        check_val("t7_short_pre_nbytes", byte_q.size(), 0);
        check_val("t7_short_pre_eof", n_eof_a, 0);

        // reset in the middle of a frame
        clear_mon();
        for (int i = 0; i < 8; i++)
            clk_nib(1'b1, 1'b0, 4'h5);
        clk_nib(1'b1, 1'b0, 4'hD);
        for (int i = 1; i <= 6; i++)
            clk_nib(1'b1, 1'b0, 4'(i));
        check_val("t6_pre_abort_nbytes", byte_q.size(), 3);
        check_val("t6_pre_abort_rxen", rxen_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("t6_async_clear", {dat_a, len_a, rxen_a, sof_a, eof_a, rxerr_a}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        clk_nib(1'b1, 1'b0, 4'h5);
        clk_nib(1'b1, 1'b0, 4'h5);
        clk_nib(1'b1, 1'b0, 4'h9);
        clk_nib(1'b1, 1'b0, 4'hD);
        clk_nib(1'b1, 1'b0, 4'h1);
        clk_nib(1'b1, 1'b0, 4'h2);
        clk_nib(1'b0, 1'b0, 4'h0);
        check_val("t6_tail_nbytes", byte_q.size(), 0);
        check_val("t6_tail_eof", n_eof_a, 0);
        tx_q = '{8'h34, 8'h56};
        send_frame(2, 1'b0, -1);
        check_val("t6_next_nbytes", byte_q.size(), 2);
        check_val("t6_next_byte0", byte_at(0), 8'h34);
        check_val("t6_next_sof0", sof_at(0), 1'b1);
        check_val("t6_next_byte1", byte_at(1), 8'h56);
        check_val("t6_next_len", last_len_a, 2);
        check_val("t6_next_err", last_err_a, 1'b0);

        check_val("no_back_to_back_rxen", n_b2b, 0);
        check_val("rxerr_only_with_eof", n_stray_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
